// File: rtl/merge_pass_sched_pkg.sv
// Shared types and constants for the merge-pass scheduler of the range sorter.
// Widths cover both memory banks; lengths carry one extra bit so N = 2^ADDR_WIDTH fits.
package merge_pass_sched_pkg;

  localparam int BANK_ADDR_WIDTH = 10;
  localparam int ADDR_WIDTH      = BANK_ADDR_WIDTH + 1;
  localparam int LEN_WIDTH       = ADDR_WIDTH + 1;
  localparam int BASE_RUN        = 16;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [LEN_WIDTH-1:0]  len_t;

  typedef struct packed {
    addr_t a_base;
    len_t  a_len;
    addr_t b_base;
    len_t  b_len;
    addr_t dst_base;
  } merge_job_t;

  typedef enum logic [2:0] {
    MS_IDLE,
    MS_SETUP,
    MS_ISSUE,
    MS_WAIT,
    MS_ADVANCE,
    MS_DONE
  } msched_state_t;

  function automatic len_t min_len(input len_t a, input len_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/merge_pass_sched_if.sv
// Job handshake between the pass scheduler (master) and merge_phase (slave).
interface merge_pass_sched_if;
  import merge_pass_sched_pkg::*;

  logic  job_valid_out;
  logic  job_ready_in;
  addr_t job_a_base_out;
  len_t  job_a_len_out;
  addr_t job_b_base_out;
  len_t  job_b_len_out;
  addr_t job_dst_base_out;
  logic  merge_width_done_in;

  modport master (
    output job_valid_out, job_a_base_out, job_a_len_out,
           job_b_base_out, job_b_len_out, job_dst_base_out,
    input  job_ready_in, merge_width_done_in
  );

  modport slave (
    input  job_valid_out, job_a_base_out, job_a_len_out,
           job_b_base_out, job_b_len_out, job_dst_base_out,
    output job_ready_in, merge_width_done_in
  );

endinterface

// File: rtl/merge_pass_sched_job_calc.sv
// Combinational job geometry for one run pair: clips both runs to N and marks
// a missing right run as copy-through (b_len = 0).
module merge_pass_sched_job_calc
  import merge_pass_sched_pkg::*;
(
  input  len_t       base_i,
  input  len_t       width_i,
  input  len_t       n_i,
  output merge_job_t job_o
);

  len_t aLen;
  len_t bStart;
  len_t bLen;
  logic unusedBits;

  // base is always below N here, so the subtractions never underflow.
  always_comb begin
    aLen   = min_len(width_i, n_i - base_i);
    bStart = base_i + aLen;
    bLen   = '0;
    if (bStart < n_i) begin
      bLen = min_len(width_i, n_i - bStart);
    end
  end

  // A copy-through job may point b_base at N itself; only the low bits are carried.
  assign job_o.a_base   = base_i[ADDR_WIDTH-1:0];
  assign job_o.a_len    = aLen;
  assign job_o.b_base   = bStart[ADDR_WIDTH-1:0];
  assign job_o.b_len    = bLen;
  assign job_o.dst_base = base_i[ADDR_WIDTH-1:0];

  assign unusedBits = ^{base_i[ADDR_WIDTH], bStart[ADDR_WIDTH]};

endmodule

// File: rtl/merge_pass_sched.sv
// Merge-pass scheduler: walks pairs of adjacent sorted runs, issues one merge job
// per pair, then doubles the run width and swaps ping/pong until one run remains.
module merge_pass_sched
  import merge_pass_sched_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      sort_done_in,
  input  len_t                      num_elems_in,
  merge_pass_sched_if.master        job_if,
  output logic                      src_sel_out,
  output len_t                      width_out,
  output logic                      pass_done_out,
  output logic [7:0]                pass_count_out,
  output logic                      busy_out,
  output logic                      all_done_out
);

  msched_state_t state_q;
  len_t          n_q;
  len_t          base_q;
  len_t          width_q;
  logic          src_sel_q;
  logic [7:0]    pass_count_q;
  logic          pass_done_q;
  logic          busy_q;
  logic          all_done_q;
  logic          job_valid_q;
  merge_job_t    job_q;

  merge_job_t         calcJob;
  logic [LEN_WIDTH:0] baseSum;
  len_t               base_d;
  len_t               width_d;

  merge_pass_sched_job_calc jobCalc (
    .base_i  (base_q),
    .width_i (width_q),
    .n_i     (n_q),
    .job_o   (calcJob)
  );

  // Saturating step to the next run pair and to the next pass width.
  assign baseSum = {1'b0, base_q} + {width_q, 1'b0};
  assign base_d  = baseSum[LEN_WIDTH] ? '1 : baseSum[LEN_WIDTH-1:0];
  assign width_d = width_q[LEN_WIDTH-1] ? '1 : {width_q[LEN_WIDTH-2:0], 1'b0};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= MS_IDLE;
      n_q          <= '0;
      base_q       <= '0;
      width_q      <= len_t'(BASE_RUN);
      src_sel_q    <= 1'b0;
      pass_count_q <= '0;
      pass_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      all_done_q   <= 1'b0;
      job_valid_q  <= 1'b0;
      job_q        <= '0;
    end else begin
      pass_done_q <= 1'b0;
      unique case (state_q)
        MS_IDLE, MS_DONE: begin
          if (sort_done_in) begin
            n_q          <= num_elems_in;
            width_q      <= len_t'(BASE_RUN);
            base_q       <= '0;
            src_sel_q    <= 1'b0;
            pass_count_q <= '0;
            if (num_elems_in <= len_t'(BASE_RUN)) begin
              state_q    <= MS_DONE;
              all_done_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              state_q    <= MS_SETUP;
              all_done_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
        end
        MS_SETUP: begin
          job_q       <= calcJob;
          job_valid_q <= 1'b1;
          state_q     <= MS_ISSUE;
        end
        MS_ISSUE: begin
          if (job_if.job_ready_in) begin
            job_valid_q <= 1'b0;
            state_q     <= MS_WAIT;
          end
        end
        MS_WAIT: begin
          if (job_if.merge_width_done_in) begin
            base_q <= base_d;
            if (base_d >= n_q) begin
              state_q     <= MS_ADVANCE;
              pass_done_q <= 1'b1;
            end else begin
              state_q <= MS_SETUP;
            end
          end
        end
        MS_ADVANCE: begin
          if (pass_count_q != 8'hFF) begin
            pass_count_q <= pass_count_q + 8'd1;
          end
          src_sel_q <= ~src_sel_q;
          width_q   <= width_d;
          base_q    <= '0;
          if (width_d >= n_q) begin
            state_q    <= MS_DONE;
            all_done_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            state_q <= MS_SETUP;
          end
        end
        default: state_q <= MS_IDLE;
      endcase
    end
  end

  assign job_if.job_valid_out    = job_valid_q;
  assign job_if.job_a_base_out   = job_q.a_base;
  assign job_if.job_a_len_out    = job_q.a_len;
  assign job_if.job_b_base_out   = job_q.b_base;
  assign job_if.job_b_len_out    = job_q.b_len;
  assign job_if.job_dst_base_out = job_q.dst_base;

  assign src_sel_out    = src_sel_q;
  assign width_out      = width_q;
  assign pass_done_out  = pass_done_q;
  assign pass_count_out = pass_count_q;
  assign busy_out       = busy_q;
  assign all_done_out   = all_done_q;

endmodule

// File: tb/tb_merge_pass_sched.sv
// Bench for merge_pass_sched: a loop-based reference model lists the expected jobs
// and pass totals for each N, and a scripted merge_phase answers the handshakes.
module tb_merge_pass_sched;
  import merge_pass_sched_pkg::*;

  typedef struct {
    int aBase;
    int aLen;
    int bBase;
    int bLen;
  } jobExp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       sortDone;
  len_t       numElems;
  logic       srcSel;
  len_t       width;
  logic       passDone;
  logic [7:0] passCount;
  logic       busy;
  logic       allDone;

  int checks = 0;
  int passed = 0;
  int hsCount = 0;
  int passDoneCount = 0;

  jobExp_t expJobs[$];
  int      expPasses;
  int      expWidth;

  merge_pass_sched_if jobIf ();

  merge_pass_sched dut (
    .clock          (clock),
    .reset          (reset),
    .sort_done_in   (sortDone),
    .num_elems_in   (numElems),
    .job_if         (jobIf),
    .src_sel_out    (srcSel),
    .width_out      (width),
    .pass_done_out  (passDone),
    .pass_count_out (passCount),
    .busy_out       (busy),
    .all_done_out   (allDone)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (jobIf.job_valid_out && jobIf.job_ready_in) hsCount++;
    if (passDone) passDoneCount++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed = passed + 1;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Pairs of runs per pass, width doubling until one run spans all of N.
  task automatic buildModel(input int n);
    int w;
    expJobs.delete();
    expPasses = 0;
    w = BASE_RUN;
    while (w < n) begin
      for (int b = 0; b < n; b += 2 * w) begin
        jobExp_t j;
        j.aBase = b;
        j.aLen  = (w < n - b) ? w : n - b;
        j.bBase = b + j.aLen;
        j.bLen  = (j.bBase >= n) ? 0 : ((w < n - j.bBase) ? w : n - j.bBase);
        expJobs.push_back(j);
      end
      expPasses++;
      w = w * 2;
    end
    expWidth = (n <= BASE_RUN) ? BASE_RUN : w;
  endtask

  task automatic applyStimulus(input int n, input int minStall, input int maxStall,
                               input bit doneInIssue, input bit sortInWait, input int abortAfter);
    int hsStart;
    int pdStart;
    int t;
    int stall;
    int gap;
    int addrMask;
    buildModel(n);
    addrMask = (1 << ADDR_WIDTH) - 1;
    hsStart  = hsCount;
    pdStart  = passDoneCount;
    $display("[TB] run N=%0d jobs=%0d passes=%0d", n, expJobs.size(), expPasses);
    sortDone = 1'b1;
    numElems = len_t'(n);
    @(negedge clock);
    sortDone = 1'b0;
    numElems = len_t'($urandom_range(0, 2047));
    if (expJobs.size() == 0) begin
      checkOutput("allDoneLatency", allDone, 1);
      checkOutput("busyShort", busy, 0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clock);
        checkOutput("noValidShort", jobIf.job_valid_out, 0);
      end
    end else begin
      checkOutput("validEarly", jobIf.job_valid_out, 0);
      checkOutput("busyStart", busy, 1);
      checkOutput("allDoneCleared", allDone, 0);
      @(negedge clock);
      checkOutput("validLatency", jobIf.job_valid_out, 1);
    end
    for (int k = 0; k < expJobs.size(); k++) begin
      t = 0;
      while (!jobIf.job_valid_out && t < 64) begin
        @(negedge clock);
        t++;
      end
      checkOutput("validTimeout", jobIf.job_valid_out, 1);
      stall = $urandom_range(minStall, maxStall);
      if (doneInIssue && stall == 0) stall = 1;
      for (int s = 0; s <= stall; s++) begin
        checkOutput("validHeld", jobIf.job_valid_out, 1);
        checkOutput("aBase", jobIf.job_a_base_out, expJobs[k].aBase);
        checkOutput("aLen", jobIf.job_a_len_out, expJobs[k].aLen);
        checkOutput("bBase", jobIf.job_b_base_out, expJobs[k].bBase & addrMask);
        checkOutput("bLen", jobIf.job_b_len_out, expJobs[k].bLen);
        checkOutput("dstBase", jobIf.job_dst_base_out, expJobs[k].aBase);
        if (s == stall) begin
          jobIf.job_ready_in = 1'b1;
        end else begin
          jobIf.job_ready_in        = 1'b0;
          jobIf.merge_width_done_in = doneInIssue && (s == 0);
        end
        @(negedge clock);
        jobIf.merge_width_done_in = 1'b0;
      end
      jobIf.job_ready_in = 1'b0;
      checkOutput("validDrop", jobIf.job_valid_out, 0);
      if (abortAfter == k + 1) begin
        #2 reset = 1'b0;
        #1;
        checkOutput("rstValid", jobIf.job_valid_out, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstAllDone", allDone, 0);
        checkOutput("rstSrcSel", srcSel, 0);
        checkOutput("rstPassCount", passCount, 0);
        checkOutput("rstWidth", width, BASE_RUN);
        checkOutput("rstPassDone", passDone, 0);
        checkOutput("rstALen", jobIf.job_a_len_out, 0);
        @(negedge clock);
        reset = 1'b1;
        return;
      end
      gap = $urandom_range(0, 3);
      if (sortInWait && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) begin
        if (sortInWait && g == 0) begin
          sortDone = 1'b1;
          numElems = len_t'(BASE_RUN);
        end
        @(negedge clock);
        sortDone = 1'b0;
      end
      jobIf.merge_width_done_in = 1'b1;
      @(negedge clock);
      jobIf.merge_width_done_in = 1'b0;
    end
    t = 0;
    while (!allDone && t < 64) begin
      @(negedge clock);
      t++;
    end
    checkOutput("allDone", allDone, 1);
    checkOutput("passCount", passCount, expPasses);
    checkOutput("srcSel", srcSel, expPasses % 2);
    checkOutput("width", width, expWidth);
    checkOutput("busyEnd", busy, 0);
    checkOutput("validEnd", jobIf.job_valid_out, 0);
    checkOutput("handshakes", hsCount - hsStart, expJobs.size());
    checkOutput("passDonePulses", passDoneCount - pdStart, expPasses);
  endtask

  initial begin
    reset                     = 1'b0;
    sortDone                  = 1'b0;
    numElems                  = '0;
    jobIf.job_ready_in        = 1'b0;
    jobIf.merge_width_done_in = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("resetValid", jobIf.job_valid_out, 0);
    checkOutput("resetWidth", width, BASE_RUN);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetAllDone", allDone, 0);
    checkOutput("resetSrcSel", srcSel, 0);
    checkOutput("resetPassCount", passCount, 0);
    reset = 1'b1;
    @(negedge clock);

    applyStimulus(64, 0, 0, 1'b0, 1'b0, 0);
    applyStimulus(40, 0, 0, 1'b0, 1'b0, 0);
    applyStimulus(16, 0, 0, 1'b0, 1'b0, 0);
    applyStimulus(0, 0, 0, 1'b0, 1'b0, 0);
    applyStimulus(64, 5, 5, 1'b0, 1'b0, 0);
    applyStimulus(64, 1, 3, 1'b1, 1'b1, 0);
    applyStimulus(17, 0, 2, 1'b0, 1'b0, 0);
    applyStimulus(64, 0, 2, 1'b0, 1'b0, 3);
    applyStimulus(32, 0, 2, 1'b0, 1'b0, 0);
    repeat (6) begin
      applyStimulus(int'($urandom_range(0, 300)), 0, 3, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 0);
    end
    applyStimulus(1 << ADDR_WIDTH, 0, 1, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/merge_pass_sched.md
Name: merge_pass_sched

Overview:
- Sequences the merge phase of the day-5 range sorter after sort_phase has left sorted runs of BASE_RUN tuple_pairs in mem_ping.
- Each pass breaks the array into pairs of adjacent runs and issues one merge job per pair to merge_phase. Between passes it doubles the run width and swaps the ping/pong source and destination roles.
- Asserts completion when a single run covers all N elements. Sits between top-level control and merge_phase; the memory mux reads its bank-select output.

Parameters:
- ADDR_WIDTH, `BANK_ADDR_WIDTH+1: element address width across both banks.
- BASE_RUN, 16: run length produced by sort_phase. Power of two, ≥2.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sort_done_in  in  1  pulse: sort phase finished; starts scheduling
- num_elems_in  in  ADDR_WIDTH+1  total element count N; sampled with sort_done_in
- job_valid_out  out  1  merge job offered
- job_ready_in  in  1  merge_phase accepts the job
- job_a_base_out  out  ADDR_WIDTH  start of left run
- job_a_len_out  out  ADDR_WIDTH+1  left run length
- job_b_base_out  out  ADDR_WIDTH  start of right run
- job_b_len_out  out  ADDR_WIDTH+1  right run length; 0 means copy-through
- job_dst_base_out  out  ADDR_WIDTH  destination start (equals job_a_base_out)
- merge_width_done_in  in  1  pulse: current job fully written back
- src_sel_out  out  1  0: read ping / write pong; 1: read pong / write ping
- width_out  out  ADDR_WIDTH+1  current run width
- pass_done_out  out  1  one-cycle pulse at end of each pass
- pass_count_out  out  8  completed passes
- busy_out  out  1  scheduling in progress
- all_done_out  out  1  level: result is complete in the bank selected by src_sel_out

Behaviour:
- Reset (reset low, async): state IDLE. All outputs 0, except width_out = BASE_RUN. Internal N and base are cleared. Reset in any state aborts immediately; no job is completed.
- States: IDLE, SETUP, ISSUE, WAIT, ADVANCE, DONE. busy_out is high in every state except IDLE and DONE.
- IDLE, or DONE, when sort_done_in is sampled:
  - Latch N. Set width = BASE_RUN, base = 0, src_sel = 0, pass_count = 0, all_done = 0.
  - If N ≤ BASE_RUN, go to DONE (zero passes). Otherwise go to SETUP.
- SETUP (1 cycle): register the job:
  - a_base = base
  - a_len = min(width, N−base)
  - b_base = base + a_len
  - b_len = (b_base ≥ N) ? 0 : min(width, N−b_base)
  - dst_base = base
  - Next state: ISSUE.
- Latency: job_valid_out rises exactly 2 cycles after sort_done_in is sampled.
- ISSUE:
  - job_valid_out stays high and all job fields stay stable until job_valid_out & job_ready_in.
  - On handshake, drop job_valid_out the next cycle and go to WAIT.
  - merge_width_done_in is ignored while in ISSUE.
- WAIT:
  - On merge_width_done_in: base += 2·width.
  - If base ≥ N, go to ADVANCE; otherwise go to SETUP.
  - The next job's job_valid_out rises 2 cycles after merge_width_done_in.
- ADVANCE (1 cycle):
  - pass_done_out = 1; pass_count += 1, saturating at 255.
  - src_sel toggles; width <<= 1; base = 0.
  - If the new width ≥ N, go to DONE; otherwise go to SETUP.
- DONE:
  - all_done_out = 1 and held.
  - src_sel_out holds and names the bank containing the final sorted data.
  - A new sort_done_in restarts scheduling from the IDLE rules above.
- Arithmetic:
  - All length and base arithmetic is ADDR_WIDTH+1 bits wide, with no wrap.
  - N = 2^ADDR_WIDTH is legal.
  - width saturates rather than overflowing. Because the width ≥ N check runs first, width never exceeds 2N.
- Simultaneous events: sort_done_in arriving during SETUP, ISSUE, WAIT or ADVANCE is ignored.
- Even/odd banking: base is always a multiple of BASE_RUN, so it is even. Bank pairing is the merge phase's concern.

Decomposition:
- aoc5.svh gets:
  - `BASE_RUN
  - a merge_job_t struct: a_base, a_len, b_base, b_len, dst_base
  - an msched_state_t enum
- Sub-module merge_job_calc: combinational min/saturation math for SETUP, taking (base, width, N) and producing merge_job_t. Reusable by merge_phase assertions.
- The FSM, counters and handshake stay in merge_pass_sched.

Test Plan:
- N=64, job_ready_in tied high:
  - Pass 1 jobs (a_base, a_len, b_base, b_len): (0,16,16,16), then (32,16,48,16).
  - Pass 2 job: (0,32,32,32).
  - Then all_done_out=1, pass_count_out=2, src_sel_out=0, width_out=64.
- N=40:
  - Pass 1 jobs: (0,16,16,16), then (32,8,40,0) as copy-through.
  - Pass 2 job: (0,32,32,8).
  - Then done with pass_count_out=2.
- N=16 and N=0: all_done_out rises 1 cycle after sort_done_in; no job_valid_out ever; pass_count_out=0; src_sel_out=0.
- Backpressure: hold job_ready_in low for 5 cycles while job_valid_out is high. All job fields stay stable, and exactly one handshake is counted.
- Extra pulses:
  - merge_width_done_in pulsed during ISSUE: ignored.
  - Second sort_done_in during WAIT: ignored; the job sequence is unchanged.
- Reset and restart:
  - Drive reset low mid-WAIT of pass 2 (N=64): outputs return to reset values asynchronously, before the next clock edge.
  - Then sort_done_in with N=32: one job (0,16,16,16); done with pass_count_out=1 and src_sel_out=1.
